// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron array.
// Holds the coupling-mode encodings, the per-neuron FSM states and the saturating clamp.
package lif_pkg;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_RING = 2'd1,
        MODE_ALL  = 2'd2,
        MODE_INH  = 2'd3
    } lif_mode_e;

    typedef enum logic {
        ST_INTEGRATE = 1'b0,
        ST_REFRACT   = 1'b1
    } lif_state_e;

    // Saturate a signed intermediate sum into the unsigned range [0, 2^w - 1].
    function automatic logic [31:0] clamp_u(input logic signed [31:0] s, input int unsigned w);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< w) - 32'sd1;
        if (s < 32'sd0) begin
            return '0;
        end
        if (s > hi) begin
            return hi;
        end
        return s;
    endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: membrane potential, refractory FSM and spike register.
// The coupling magnitude arrives precomputed; inhibit_i selects subtraction instead of addition.
module lif_neuron
    import lif_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               LEAK_SHIFT = 4,
    parameter int               REFR_W     = 4,
    parameter int               SUM_W      = 19,
    parameter logic [WIDTH-1:0] RESET_V    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena_i,
    input  logic [4:0]        base_current_i,
    input  logic [SUM_W-1:0]  c_i,
    input  logic              inhibit_i,
    input  logic [WIDTH-1:0]  threshold_i,
    input  logic [REFR_W-1:0] refract_cycles_i,
    output logic              spike_o,
    output logic [WIDTH-1:0]  v_o
);

    lif_state_e        state_q, state_d;
    logic [WIDTH-1:0]  v_q, v_d;
    logic [REFR_W-1:0] rc_q, rc_d;
    logic              spike_q, spike_d;

    logic [SUM_W-1:0]  sum_u;
    logic [WIDTH-1:0]  s_clamped;
    logic [WIDTH-1:0]  thr_eff;

    // Two's-complement sum wide enough that neither the all-to-all excitation nor the
    // inhibitory subtraction can wrap before the clamp.
    always_comb begin
        sum_u = SUM_W'(v_q) - SUM_W'(v_q >> LEAK_SHIFT) + SUM_W'(base_current_i);
        if (inhibit_i) begin
            sum_u = sum_u - c_i;
        end else begin
            sum_u = sum_u + c_i;
        end
        s_clamped = WIDTH'(clamp_u(32'(signed'(sum_u)), WIDTH));
        thr_eff   = (threshold_i == '0) ? WIDTH'(1) : threshold_i;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        rc_d    = rc_q;
        spike_d = 1'b0;
        if (ena_i) begin
            case (state_q)
                ST_INTEGRATE: begin
                    if (s_clamped >= thr_eff) begin
                        spike_d = 1'b1;
                        v_d     = '0;
                        if (refract_cycles_i != '0) begin
                            state_d = ST_REFRACT;
                            rc_d    = refract_cycles_i;
                        end
                    end else begin
                        v_d = s_clamped;
                    end
                end
                ST_REFRACT: begin
                    v_d  = '0;
                    rc_d = rc_q - REFR_W'(1);
                    if (rc_q == REFR_W'(1)) begin
                        state_d = ST_INTEGRATE;
                    end
                end
                default: state_d = ST_INTEGRATE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all neurons see the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INTEGRATE;
            v_q     <= RESET_V;
            rc_q    <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            rc_q    <= rc_d;
            spike_q <= spike_d;
        end
    end

    assign spike_o = spike_q;
    assign v_o     = v_q;

endmodule

// File: rtl/lif_array.sv
// Array of coupled LIF neurons with a shared threshold, selectable coupling topology
// and a registered membrane-potential probe.
module lif_array
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int WIDTH       = 8,
    parameter int LEAK_SHIFT  = 4,
    parameter int PHASE_STEP  = 100,
    parameter int REFR_W      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic [4:0]                     base_current,
    input  logic [7:0]                     coupling_strength,
    input  logic [1:0]                     mode,
    input  logic [WIDTH-1:0]               threshold,
    input  logic [REFR_W-1:0]              refract_cycles,
    input  logic [$clog2(NUM_NEURONS)-1:0] probe_sel,
    output logic [NUM_NEURONS-1:0]         spikes,
    output logic [WIDTH-1:0]               probe_state
);

    localparam int SEL_W = $clog2(NUM_NEURONS);
    localparam int CNT_W = SEL_W + 1;
    localparam int SUM_W = WIDTH + SEL_W + 9;

    lif_mode_e              mode_e;
    logic                   inhibit;
    logic [NUM_NEURONS-1:0] spike_all;
    logic [WIDTH-1:0]       v_all [NUM_NEURONS];
    logic [WIDTH-1:0]       probe_q, probe_d;

    assign mode_e  = lif_mode_e'(mode);
    assign inhibit = (mode_e == MODE_INH);

    for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_neuron
        localparam int               PRED    = (i + NUM_NEURONS - 1) % NUM_NEURONS;
        localparam logic [WIDTH-1:0] RESET_V = WIDTH'(i * PHASE_STEP);

        logic [CNT_W-1:0] others;
        logic [SUM_W-1:0] c_val;

        // Coupling is driven from the registered spikes, so partners react one update later.
        always_comb begin
            others = '0;
            for (int j = 0; j < NUM_NEURONS; j++) begin
                if (j != i) begin
                    others = others + CNT_W'(spike_all[j]);
                end
            end
            c_val = '0;
            case (mode_e)
                MODE_RING, MODE_INH: c_val = spike_all[PRED] ? SUM_W'(coupling_strength) : '0;
                MODE_ALL:            c_val = SUM_W'(coupling_strength) * SUM_W'(others);
                default:             c_val = '0;
            endcase
        end

        lif_neuron #(
            .WIDTH      (WIDTH),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFR_W     (REFR_W),
            .SUM_W      (SUM_W),
            .RESET_V    (RESET_V)
        ) u_neuron (
            .clk              (clk),
            .rst              (rst),
            .ena_i            (ena),
            .base_current_i   (base_current),
            .c_i              (c_val),
            .inhibit_i        (inhibit),
            .threshold_i      (threshold),
            .refract_cycles_i (refract_cycles),
            .spike_o          (spike_all[i]),
            .v_o              (v_all[i])
        );
    end

    // Selects beyond the last neuron (non power-of-two arrays) read as zero.
    always_comb begin
        probe_d = '0;
        if (int'(probe_sel) < NUM_NEURONS) begin
            probe_d = v_all[probe_sel];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            probe_q <= '0;
        end else begin
            probe_q <= probe_d;
        end
    end

    assign spikes      = spike_all;
    assign probe_state = probe_q;

endmodule
